// File: rtl/vocab_writer_if.sv
// vocab_writer_if: character stream from the host/UART loader into vocab_writer.
//   in_valid  host -> writer  character valid
//   in_data   host -> writer  character (0x00 is accepted and dropped)
//   in_last   host -> writer  character closes the current word
//   seal      host -> writer  end of list
//   in_ready  writer -> host  character accepted when in_valid & in_ready
interface vocab_writer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  seal;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output seal,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  seal,
    output in_ready
  );
endinterface

// File: rtl/vocab_writer.sv
// vocab_writer: packs a character stream into the SRAM region [start_addr..end_addr],
// writing each word followed by a 0x00 terminator. When the region runs out, the partial
// word is erased (its first location is overwritten with 0x00) and the block stops.
//   clk, rst_n               clock, asynchronous active-low reset
//   cs                       rising edge starts a load, low aborts to idle
//   start_addr, end_addr     region bounds (inclusive), sampled on cs rise
//   host (slave)             valid/ready character stream plus seal
//   sram_cs/we/addr/din      registered write port to the SRAM
//   wr_ptr, word_count       next free address, complete words written
//   busy, done, overflow     status (done/overflow sticky until next start)
module vocab_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  vocab_writer_if.slave         host,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_TERM  = 3'd2;
  localparam logic [2:0] ST_ERASE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_OVF   = 3'd5;

  localparam logic [ADDR_WIDTH:0]   PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] CHAR_NULL = {DATA_WIDTH{1'b0}};

  logic [2:0]            state_r;
  logic                  cs_d_r;
  logic [ADDR_WIDTH:0]   end_r;
  logic [ADDR_WIDTH:0]   ptr_r;
  logic [ADDR_WIDTH:0]   word_start_r;
  logic [ADDR_WIDTH:0]   word_count_r;
  logic                  seal_pend_r;
  logic                  done_r;
  logic                  overflow_r;
  logic                  sram_we_r;
  logic [ADDR_WIDTH-1:0] sram_addr_r;
  logic [DATA_WIDTH-1:0] sram_din_r;
  logic                  partial_s;
  logic                  room_s;

  // A word is in progress when characters were written since the last terminator.
  assign partial_s = (ptr_r > word_start_r);
  // A character fits only if the terminator still fits behind it (ptr < end).
  assign room_s    = (ptr_r < end_r);

  assign host.in_ready = (state_r == ST_LOAD) & ~host.seal;
  assign busy          = (state_r == ST_LOAD) | (state_r == ST_TERM) | (state_r == ST_ERASE);
  assign sram_we       = sram_we_r;
  assign sram_cs       = sram_we_r;
  assign sram_addr     = sram_addr_r;
  assign sram_din      = sram_din_r;
  assign wr_ptr        = ptr_r;
  assign word_count    = word_count_r;
  assign done          = done_r;
  assign overflow      = overflow_r;

  // Load state machine, pointers, status flags and the registered SRAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cs_d_r       <= 1'b0;
      end_r        <= '0;
      ptr_r        <= '0;
      word_start_r <= '0;
      word_count_r <= '0;
      seal_pend_r  <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_addr_r  <= '0;
      sram_din_r   <= '0;
    end else begin
      cs_d_r    <= cs;
      sram_we_r <= 1'b0;
      if (!cs) begin
        // Abort: counters and sticky flags are kept for the host to read.
        state_r     <= ST_IDLE;
        seal_pend_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (!cs_d_r) begin
              end_r        <= {1'b0, end_addr};
              ptr_r        <= {1'b0, start_addr};
              word_start_r <= {1'b0, start_addr};
              word_count_r <= '0;
              done_r       <= 1'b0;
              overflow_r   <= 1'b0;
              seal_pend_r  <= 1'b0;
              state_r      <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            // seal wins over a same-cycle character (in_ready is low then).
            if (host.seal) begin
              if (partial_s) begin
                seal_pend_r <= 1'b1;
                state_r     <= ST_TERM;
              end else begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end
            end else if (host.in_valid) begin
              if (host.in_data == CHAR_NULL) begin
                if (host.in_last && partial_s) begin
                  state_r <= ST_TERM;
                end
              end else if (room_s) begin
                sram_we_r   <= 1'b1;
                sram_addr_r <= ptr_r[ADDR_WIDTH-1:0];
                sram_din_r  <= host.in_data;
                ptr_r       <= ptr_r + PTR_ONE;
                if (host.in_last) begin
                  state_r <= ST_TERM;
                end
              end else begin
                overflow_r <= 1'b1;
                state_r    <= partial_s ? ST_ERASE : ST_OVF;
              end
            end
          end
          ST_TERM: begin
            sram_we_r    <= 1'b1;
            sram_addr_r  <= ptr_r[ADDR_WIDTH-1:0];
            sram_din_r   <= CHAR_NULL;
            ptr_r        <= ptr_r + PTR_ONE;
            word_start_r <= ptr_r + PTR_ONE;
            word_count_r <= word_count_r + PTR_ONE;
            if (seal_pend_r) begin
              seal_pend_r <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_LOAD;
            end
          end
          ST_ERASE: begin
            // Null at the word's first location hides the truncated word from the reader.
            sram_we_r   <= 1'b1;
            sram_addr_r <= word_start_r[ADDR_WIDTH-1:0];
            sram_din_r  <= CHAR_NULL;
            ptr_r       <= word_start_r;
            state_r     <= ST_OVF;
          end
          ST_DONE: state_r <= ST_DONE;
          ST_OVF:  state_r <= ST_OVF;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vocab_writer.sv
// tb_vocab_writer: directed and randomized loads checked against a word-level model of
// the packing rules; every SRAM write is matched against the model's expected write list.
module tb_vocab_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic [3:0] start_addr = 4'd0;
  logic [3:0] end_addr = 4'd0;
  logic       sram_cs, sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic [4:0] wr_ptr, word_count;
  logic       busy, done, overflow;

  vocab_writer_if #(.DATA_WIDTH(8)) host_if ();

  vocab_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .start_addr(start_addr), .end_addr(end_addr),
    .host(host_if), .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .wr_ptr(wr_ptr), .word_count(word_count), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen = 0;
  logic [7:0] tb_mem [16];

  // ---------------- behavioural model ----------------
  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];
  int  m_p, m_ws, m_end, m_cnt;
  bit  m_done, m_ovf;

  function automatic void m_start(int s, int e);
    m_p = s; m_ws = s; m_end = e; m_cnt = 0; m_done = 0; m_ovf = 0;
  endfunction

  function automatic void m_term();
    exp_q.push_back('{m_p, 0});
    m_p++; m_ws = m_p; m_cnt++;
  endfunction

  function automatic void m_char(int c, bit last);
    if (m_done || m_ovf) return;
    if (c == 0) begin
      if (last && m_p > m_ws) m_term();
    end else if (m_p < m_end) begin
      exp_q.push_back('{m_p, c});
      m_p++;
      if (last) m_term();
    end else begin
      m_ovf = 1;
      if (m_p > m_ws) begin
        exp_q.push_back('{m_ws, 0});
        m_p = m_ws;
      end
    end
  endfunction

  function automatic void m_seal();
    if (m_done || m_ovf) return;
    if (m_p > m_ws) m_term();
    m_done = 1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare process: every SRAM write must be the next write the model predicts.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sram_we === 1'b1) begin
        wr_seen++;
        tb_mem[sram_addr] = sram_din;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {28'd0, sram_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_cs", {31'd0, sram_cs}, 32'd1);
          chk("wr_addr", {28'd0, sram_addr}, e.a);
          chk("wr_data", {24'd0, sram_din}, e.d);
        end
      end else if (sram_cs !== 1'b0) begin
        chk("idle_sram_cs", {31'd0, sram_cs}, 32'd0);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int s, input int e);
    cs = 1'b0;
    idle(1);
    start_addr = s[3:0];
    end_addr = e[3:0];
    cs = 1'b1;
    idle(1);
    m_start(s, e);
  endtask

  task automatic send(input logic [7:0] c, input bit last, output int stalls);
    stalls = 0;
    host_if.in_valid = 1'b1;
    host_if.in_data = c;
    host_if.in_last = last;
    forever begin
      @(negedge clk);
      if (host_if.in_ready === 1'b1) break;
      stalls++;
      if (stalls > 40) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (stalls <= 40) m_char(c, last);
    @(posedge clk);
    #1;
    host_if.in_valid = 1'b0;
    host_if.in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    int st;
    for (int i = 0; i < s.len(); i++) begin
      if (!m_ovf) send(s[i], last_on_end && (i == s.len() - 1), st);
    end
  endtask

  task automatic do_seal();
    int n;
    if (m_ovf || m_done) return;
    m_seal();
    host_if.seal = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
      if (n > 20) begin
        chk("seal_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    host_if.seal = 1'b0;
  endtask

  task automatic end_chk();
    idle(3);
    chk("pending_writes", exp_q.size(), 32'd0);
    chk("wr_ptr", {27'd0, wr_ptr}, m_p);
    chk("word_count", {27'd0, word_count}, m_cnt);
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("busy", {31'd0, busy}, {31'd0, !(m_done || m_ovf)});
    chk("in_ready", {31'd0, host_if.in_ready}, {31'd0, !(m_done || m_ovf)});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st, w0, nw, len, c;
    bit lst;
    logic [7:0] t1 [8];
    logic [7:0] t3 [4];
    t1 = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6F, 8'h67, 8'h00};
    t3 = '{8'h61, 8'h62, 8'h63, 8'h00};
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'hFF;
    host_if.in_valid = 1'b0;
    host_if.in_data = 8'h00;
    host_if.in_last = 1'b0;
    host_if.seal = 1'b0;

    // Reset state
    #12;
    chk("rst_wr_ptr", {27'd0, wr_ptr}, 32'd0);
    chk("rst_word_count", {27'd0, word_count}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, overflow, sram_we}, 32'd0);
    chk("rst_in_ready", {31'd0, host_if.in_ready}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: two words then seal
    start_load(0, 15);
    send_str("cat", 1'b1);
    send_str("dog", 1'b1);
    do_seal();
    end_chk();
    for (int i = 0; i < 8; i++) chk("t1_mem", {24'd0, tb_mem[i]}, {24'd0, t1[i]});
    chk("t1_wc", {27'd0, word_count}, 32'd2);
    chk("t1_ptr", {27'd0, wr_ptr}, 32'd8);
    chk("t1_done_ovf", {30'd0, done, overflow}, 32'd2);

    // 2: overflow mid-word erases the partial word
    start_load(12, 15);
    send_str("hello", 1'b1);
    end_chk();
    chk("t2_mem12", {24'd0, tb_mem[12]}, 32'h00);
    chk("t2_mem13", {24'd0, tb_mem[13]}, 32'h65);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_wc", {27'd0, word_count}, 32'd0);
    chk("t2_ptr", {27'd0, wr_ptr}, 32'd12);
    chk("t2_ready", {31'd0, host_if.in_ready}, 32'd0);

    // 3: exact fit, then one more char overflows without a write
    start_load(12, 15);
    send_str("abc", 1'b1);
    end_chk();
    for (int i = 0; i < 4; i++) chk("t3_mem", {24'd0, tb_mem[12 + i]}, {24'd0, t3[i]});
    chk("t3_ptr", {27'd0, wr_ptr}, 32'd16);
    chk("t3_wc", {27'd0, word_count}, 32'd1);
    w0 = wr_seen;
    send(8'h78, 1'b0, st);
    end_chk();
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_no_write", wr_seen, w0);

    // 4: TERM stall of one cycle, seal beats a same-cycle char
    start_load(0, 15);
    send(8'h61, 1'b1, st);
    send(8'h62, 1'b0, st);
    chk("t4_term_stall", st, 32'd1);
    host_if.in_valid = 1'b1;
    host_if.in_data = 8'h7A;
    host_if.seal = 1'b1;
    @(negedge clk);
    chk("t4_ready_seal", {31'd0, host_if.in_ready}, 32'd0);
    host_if.seal = 1'b0;
    host_if.in_valid = 1'b0;
    do_seal();
    end_chk();
    chk("t4_wc", {27'd0, word_count}, 32'd2);
    chk("t4_mem3", {24'd0, tb_mem[3]}, 32'h00);

    // 5: abort mid-word, then restart
    start_load(0, 15);
    send_str("ca", 1'b0);
    cs = 1'b0;
    idle(1);
    chk("t5_we", {31'd0, sram_we}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    idle(3);
    chk("t5_wc", {27'd0, word_count}, 32'd0);
    chk("t5_pending", exp_q.size(), 32'd0);
    start_load(4, 15);
    chk("t5_restart_ptr", {27'd0, wr_ptr}, 32'd4);
    chk("t5_restart_flags", {27'd0, word_count} | {30'd0, done, overflow}, 32'd0);
    send_str("x", 1'b1);
    do_seal();
    end_chk();
    chk("t5_mem4", {24'd0, tb_mem[4]}, 32'h78);
    chk("t5_mem5", {24'd0, tb_mem[5]}, 32'h00);

    // 6: async reset during TERM
    start_load(0, 15);
    send(8'h71, 1'b1, st);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_outs", {18'd0, wr_ptr, word_count, busy, done, overflow, sram_we}, 32'd0);
    chk("t6_cs_ready", {30'd0, sram_cs, host_if.in_ready}, 32'd0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Randomized loads
    for (int it = 0; it < 30; it++) begin
      int s, e;
      s = $urandom_range(0, 15);
      e = $urandom_range(s, 15);
      start_load(s, e);
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          if (!m_ovf) begin
            c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(8'h61, 8'h7A);
            lst = (k == len - 1) && ($urandom_range(0, 5) != 0);
            send(c[7:0], lst, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
        end
      end
      if ($urandom_range(0, 3) != 0) do_seal();
      end_chk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
